// File: rtl/fetch_unit_pkg.sv
// ===========================================================================
// fetch_unit_pkg : shared types and constants for the instruction fetch unit
// Revision 1.0
// ===========================================================================
`default_nettype none

package fetch_unit_pkg;

   localparam logic [31:0] PC_RESET_VAL = 32'h1eceb000;
   localparam logic [3:0]  RMASK_WORD   = 4'hF;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_pkt_t;

   typedef enum logic [1:0] {
      ISSUE   = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      PC_HOLD   = 2'd0,
      PC_SEQ    = 2'd1,
      PC_BRANCH = 2'd2
   } pc_sel_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_pc_gen.sv
// ===========================================================================
// fetch_pc_gen : program counter register with reset / +4 / branch-target mux
// Revision 1.0
// ===========================================================================
`default_nettype none

module fetch_pc_gen
   import fetch_unit_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  PC_RESET = XLEN'(PC_RESET_VAL)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  pc_sel_t         pc_sel_i,
   input  logic [XLEN-1:0] seq_base_i,
   input  logic [XLEN-1:0] target_i,
   output logic [XLEN-1:0] pc_o
);

   localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   // Sequential step is taken from the address just answered, not from pc_q
   always_comb begin
      pc_d = pc_q;
      case (pc_sel_i)
         PC_SEQ:    pc_d = seq_base_i + WORD_STEP;
         PC_BRANCH: pc_d = target_i;
         default:   pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ===========================================================================
// fetch_unit : single-outstanding instruction fetcher feeding the instruction
// queue; FETCH_PERF_CNT_EN adds stall/discard counters. Revision 1.0
// ===========================================================================
`default_nettype none

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  PC_RESET = XLEN'(PC_RESET_VAL)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [XLEN-1:0]   imem_addr,
   output logic [3:0]        imem_rmask,
   input  logic [XLEN-1:0]   imem_rdata,
   input  logic              imem_resp,
   input  logic              iq_full_in,
   output logic              iq_enqueue_out,
   output logic [2*XLEN-1:0] iq_wdata_out,
   input  logic              global_branch_signal,
   input  logic [XLEN-1:0]   branch_target_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_discard_cnt
`endif
);

   localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [3:0]      rmask_q, rmask_d;
   logic [XLEN-1:0] pc;
   pc_sel_t         pc_sel;
   logic            enq;

   fetch_pc_gen #(
      .XLEN     (XLEN),
      .PC_RESET (PC_RESET)
   ) u_pc_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_sel_i   (pc_sel),
      .seq_base_i (addr_q),
      .target_i   (branch_target_pc),
      .pc_o       (pc)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rmask_d = rmask_q;
      pc_sel  = PC_HOLD;
      enq     = 1'b0;
      case (state_q)
         ISSUE: begin
            if (global_branch_signal) begin
               pc_sel = PC_BRANCH;
            end else if (!iq_full_in) begin
               addr_d  = pc;
               rmask_d = RMASK_WORD;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_resp) begin
               if (global_branch_signal) begin
                  pc_sel  = PC_BRANCH;
                  rmask_d = 4'h0;
                  state_d = ISSUE;
               end else begin
                  enq    = 1'b1;
                  pc_sel = PC_SEQ;
                  // Queue full here already accounts for this cycle's enqueue
                  if (!iq_full_in) begin
                     addr_d = addr_q + WORD_STEP;
                  end else begin
                     rmask_d = 4'h0;
                     state_d = ISSUE;
                  end
               end
            end else if (global_branch_signal) begin
               pc_sel  = PC_BRANCH;
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (global_branch_signal) begin
               pc_sel = PC_BRANCH;
            end
            if (imem_resp) begin
               rmask_d = 4'h0;
               state_d = ISSUE;
            end
         end
         default: begin
            rmask_d = 4'h0;
            state_d = ISSUE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ISSUE;
         addr_q  <= '0;
         rmask_q <= 4'h0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rmask_q <= rmask_d;
      end
   end

   assign imem_addr      = addr_q;
   assign imem_rmask     = rmask_q;
   assign iq_enqueue_out = enq;
   assign iq_wdata_out   = enq ? {addr_q, imem_rdata} : '0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] discard_cnt_q;
   logic        stall_evt;
   logic        discard_evt;

   assign stall_evt   = (state_q == ISSUE) && iq_full_in;
   assign discard_evt = imem_resp &&
                        ((state_q == DISCARD) ||
                         ((state_q == WAIT) && global_branch_signal));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q   <= '0;
         discard_cnt_q <= '0;
      end else begin
         if (stall_evt && (stall_cnt_q != 32'hFFFFFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (discard_evt && (discard_cnt_q != 32'hFFFFFFFF)) begin
            discard_cnt_q <= discard_cnt_q + 32'd1;
         end
      end
   end

   assign perf_stall_cnt   = stall_cnt_q;
   assign perf_discard_cnt = discard_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ===========================================================================
// tb_fetch_unit : cycle-table stimulus with an enqueue scoreboard
// Revision 1.0
// ===========================================================================
`default_nettype none

module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata = '0;
   logic        imem_resp = 1'b0;
   logic        iq_full_in = 1'b0;
   logic        iq_enqueue_out;
   logic [63:0] iq_wdata_out;
   logic        global_branch_signal = 1'b0;
   logic [31:0] branch_target_pc = '0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_discard_cnt;
`endif

   fetch_unit dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .imem_addr            (imem_addr),
      .imem_rmask           (imem_rmask),
      .imem_rdata           (imem_rdata),
      .imem_resp            (imem_resp),
      .iq_full_in           (iq_full_in),
      .iq_enqueue_out       (iq_enqueue_out),
      .iq_wdata_out         (iq_wdata_out),
      .global_branch_signal (global_branch_signal),
      .branch_target_pc     (branch_target_pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_stall_cnt       (perf_stall_cnt),
      .perf_discard_cnt     (perf_discard_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        full;
      logic        flush;
      logic [31:0] tgt;
      logic        resp;
      logic [31:0] rdata;
      logic [3:0]  exp_rmask;
      logic [31:0] exp_addr;
      logic        exp_enq;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] sb[$];
   int          n_vec  = 0;
   int          n_fail = 0;

   localparam logic [31:0] RST_PC = 32'h1eceb000;
   localparam logic [3:0]  RM     = 4'hF;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic full, input logic flush, input logic [31:0] tgt,
                               input logic resp, input logic [31:0] rdata,
                               input logic [3:0] rmask, input logic [31:0] addr, input logic enq);
      vec_t v;
      v.full = full; v.flush = flush; v.tgt = tgt; v.resp = resp; v.rdata = rdata;
      v.exp_rmask = rmask; v.exp_addr = addr; v.exp_enq = enq;
      vecs.push_back(v);
   endfunction

   task automatic idle_inputs();
      iq_full_in = 1'b0; global_branch_signal = 1'b0; branch_target_pc = '0;
      imem_resp = 1'b0; imem_rdata = '0;
   endtask

   // Holds reset over an edge, checks reset outputs, releases mid-cycle
   task automatic do_reset(input string nm);
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk({nm, " rst rmask"}, 64'(imem_rmask), 64'(4'h0));
      chk({nm, " rst addr"},  64'(imem_addr),  64'(32'h0));
      chk({nm, " rst enq"},   64'(iq_enqueue_out), 64'(1'b0));
      chk({nm, " rst wdata"}, iq_wdata_out, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_vecs(input string nm);
      logic [63:0] exp;
      foreach (vecs[i]) begin
         iq_full_in           = vecs[i].full;
         global_branch_signal = vecs[i].flush;
         branch_target_pc     = vecs[i].tgt;
         imem_resp            = vecs[i].resp;
         imem_rdata           = vecs[i].rdata;
         if (vecs[i].exp_enq) sb.push_back({vecs[i].exp_addr, vecs[i].rdata});
         #1;
         chk($sformatf("%s[%0d] rmask", nm, i), 64'(imem_rmask), 64'(vecs[i].exp_rmask));
         if (vecs[i].exp_rmask != 4'h0)
            chk($sformatf("%s[%0d] addr", nm, i), 64'(imem_addr), 64'(vecs[i].exp_addr));
         chk($sformatf("%s[%0d] enq", nm, i), 64'(iq_enqueue_out), 64'(vecs[i].exp_enq));
         if (iq_enqueue_out) begin
            if (sb.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL %s[%0d] sb: got enqueue %h expected none", nm, i, iq_wdata_out);
            end else begin
               exp = sb.pop_front();
               chk($sformatf("%s[%0d] wdata", nm, i), iq_wdata_out, exp);
            end
         end
         @(posedge clk); #1;
      end
      vecs.delete();
      idle_inputs();
      chk({nm, " sb empty"}, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Sustained fetch, 2-cycle memory latency, queue never full
      do_reset("seqA");
      add(0,0,0,0,0,        4'h0, 0,        0);
      add(0,0,0,0,0,        RM,   RST_PC,   0);
      add(0,0,0,0,0,        RM,   RST_PC,   0);
      add(0,0,0,1,32'h13,   RM,   RST_PC,   1);
      add(0,0,0,0,0,        RM,   RST_PC+4, 0);
      add(0,0,0,0,0,        RM,   RST_PC+4, 0);
      add(0,0,0,1,32'h293,  RM,   RST_PC+4, 1);
      add(0,0,0,0,0,        RM,   RST_PC+8, 0);
      run_vecs("seqA");

      // Queue full for 5 cycles, then stall on full after a response
      do_reset("seqB");
      for (int k = 0; k < 5; k++) add(1,0,0,0,0, 4'h0, 0, 0);
      add(0,0,0,0,0,        4'h0, 0,        0);
      add(1,0,0,1,32'hAA55, RM,   RST_PC,   1);
      add(0,0,0,0,0,        4'h0, 0,        0);
      add(0,0,0,0,0,        RM,   RST_PC+4, 0);
      run_vecs("seqB");
`ifdef FETCH_PERF_CNT_EN
      chk("seqB stall_cnt", 64'(perf_stall_cnt), 64'd5);
`endif

      // Flush while second request outstanding, response 3 cycles later
      do_reset("seqC");
      add(0,0,0,0,0,              4'h0, 0,            0);
      add(0,0,0,0,0,              RM,   RST_PC,       0);
      add(0,0,0,1,32'h1111,       RM,   RST_PC,       1);
      add(0,1,32'h1000,0,0,       RM,   RST_PC+4,     0);
      add(0,0,0,0,0,              RM,   RST_PC+4,     0);
      add(0,0,0,0,0,              RM,   RST_PC+4,     0);
      add(0,0,0,1,32'hDEAD,       RM,   RST_PC+4,     0);
      add(0,0,0,0,0,              4'h0, 0,            0);
      add(0,0,0,0,0,              RM,   32'h1000,     0);
      run_vecs("seqC");
`ifdef FETCH_PERF_CNT_EN
      chk("seqC discard_cnt", 64'(perf_discard_cnt), 64'd1);
`endif

      // Flush coincident with response
      do_reset("seqD");
      add(0,0,0,0,0,              4'h0, 0,            0);
      add(0,1,32'h4000,1,32'hBAD, RM,   RST_PC,       0);
      add(0,0,0,0,0,              4'h0, 0,            0);
      add(0,0,0,1,32'h4444,       RM,   32'h4000,     1);
      add(0,0,0,0,0,              RM,   32'h4004,     0);
      run_vecs("seqD");
`ifdef FETCH_PERF_CNT_EN
      chk("seqD discard_cnt", 64'(perf_discard_cnt), 64'd1);
`endif

      // Two flushes during one discard window
      do_reset("seqE");
      add(0,0,0,0,0,              4'h0, 0,            0);
      add(0,1,32'h2000,0,0,       RM,   RST_PC,       0);
      add(0,1,32'h3000,0,0,       RM,   RST_PC,       0);
      add(0,0,0,1,32'hBAD,        RM,   RST_PC,       0);
      add(0,0,0,0,0,              4'h0, 0,            0);
      add(0,0,0,0,0,              RM,   32'h3000,     0);
      run_vecs("seqE");

      // Redirect while idle and PC wrap at the top of the address space
      do_reset("seqG");
      add(0,1,32'hFFFFFFFC,0,0,   4'h0, 0,            0);
      add(0,0,0,0,0,              4'h0, 0,            0);
      add(0,0,0,1,32'h7777,       RM,   32'hFFFFFFFC, 1);
      add(0,0,0,1,32'h8888,       RM,   32'h0,        1);
      add(0,0,0,0,0,              RM,   32'h4,        0);
      run_vecs("seqG");

      // Asynchronous reset mid-request, then a stale response
      do_reset("seqF");
      add(0,0,0,0,0,              4'h0, 0,            0);
      add(0,0,0,0,0,              RM,   RST_PC,       0);
      run_vecs("seqF");
      imem_resp = 1'b1; imem_rdata = 32'hBAD;
      #2 rst_n = 1'b0;
      #1;
      chk("seqF async rmask", 64'(imem_rmask), 64'(4'h0));
      chk("seqF async addr",  64'(imem_addr),  64'(32'h0));
      chk("seqF async enq",   64'(iq_enqueue_out), 64'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      add(0,0,0,1,32'hBAD,        4'h0, 0,            0);
      add(0,0,0,0,0,              RM,   RST_PC,       0);
      run_vecs("seqF2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
